// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor: samples a falling-edge 4-bit ripple counter, extends
// its count, flags bad steps and latches a fault after repeated errors.
module ripple_count_monitor #(
    parameter int EXT_W      = 12,
    parameter int ERR_LIMIT  = 3,
    parameter bit ALLOW_HOLD = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       q_in,
    input  logic             clear,
    output logic [EXT_W-1:0] ext_count,
    output logic             wrap,
    output logic             step_err,
    output logic [7:0]       err_cnt,
    output logic             locked,
    output logic             fault
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [3:0]       LIMIT   = 4'(ERR_LIMIT);
    localparam logic [EXT_W-1:0] EXT_ONE = EXT_W'(1);

    state_t           state, state_n;
    logic [3:0]       q_s, q_p;
    logic [1:0]       vld, vld_n;
    logic [3:0]       cerr, cerr_n, cerr_inc;
    logic [EXT_W-1:0] ext_n;
    logic [7:0]       err_n;
    logic             wrap_n, serr_n;

    logic [3:0] d;
    logic       valid;
    logic       step_inc;
    logic       step_hold;
    logic       at_wrap;

    assign d         = q_s - q_p;
    assign valid     = (vld == 2'b11);
    assign step_inc  = (d == 4'd1);
    assign step_hold = (d == 4'd0) && ALLOW_HOLD;
    assign at_wrap   = step_inc && (q_p == 4'd15);
    assign cerr_inc  = cerr + 4'd1;

    assign locked = (state == TRACK);
    assign fault  = (state == FAULT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SYNC;
            q_s       <= '0;
            q_p       <= '0;
            vld       <= '0;
            cerr      <= '0;
            ext_count <= '0;
            err_cnt   <= '0;
            wrap      <= 1'b0;
            step_err  <= 1'b0;
        end else begin
            state     <= state_n;
            q_s       <= q_in;
            q_p       <= q_s;
            vld       <= vld_n;
            cerr      <= cerr_n;
            ext_count <= ext_n;
            err_cnt   <= err_n;
            wrap      <= wrap_n;
            step_err  <= serr_n;
        end
    end

    always_comb begin
        state_n = state;
        vld_n   = {vld[0], 1'b1};
        cerr_n  = cerr;
        ext_n   = ext_count;
        err_n   = err_cnt;
        wrap_n  = 1'b0;
        serr_n  = 1'b0;
        // clear wins even over a step that would otherwise fault
        if (clear) begin
            state_n = SYNC;
            vld_n   = '0;
            cerr_n  = '0;
            ext_n   = '0;
            err_n   = '0;
        end else begin
            unique case (state)
                SYNC: begin
                    if (valid && (q_s == 4'd0)) begin
                        state_n = TRACK;
                        ext_n   = '0;
                        cerr_n  = '0;
                    end
                end
                TRACK: begin
                    if (valid) begin
                        unique case (1'b1)
                            step_inc: begin
                                ext_n  = ext_count + EXT_ONE;
                                wrap_n = at_wrap;
                                cerr_n = '0;
                            end
                            step_hold: begin
                                cerr_n = '0;
                            end
                            default: begin
                                serr_n = 1'b1;
                                cerr_n = cerr_inc;
                                ext_n  = {ext_count[EXT_W-1:4], q_s};
                                err_n  = (err_cnt == 8'hff) ? err_cnt
                                                            : err_cnt + 8'd1;
                                if (cerr_inc == LIMIT)
                                    state_n = FAULT;
                            end
                        endcase
                    end
                end
                FAULT: begin
                    state_n = FAULT;
                end
                default: begin
                    state_n = SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// tb_ripple_count_monitor: directed vector tables plus hand-written
// sequences for fault, hold policy, async reset and saturation.
module tb_ripple_count_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  q_in = 4'd0;
    logic        clear = 1'b0;

    logic [11:0] a_ext;
    logic        a_wrap, a_serr, a_lk, a_ft;
    logic [7:0]  a_err;
    logic [4:0]  b_ext;
    logic        b_wrap, b_serr, b_lk, b_ft;
    logic [7:0]  b_err;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ripple_count_monitor #(
        .EXT_W(12), .ERR_LIMIT(3), .ALLOW_HOLD(1'b1)
    ) u_a (
        .clk(clk), .reset(reset), .q_in(q_in), .clear(clear),
        .ext_count(a_ext), .wrap(a_wrap), .step_err(a_serr),
        .err_cnt(a_err), .locked(a_lk), .fault(a_ft)
    );

    ripple_count_monitor #(
        .EXT_W(5), .ERR_LIMIT(3), .ALLOW_HOLD(1'b0)
    ) u_b (
        .clk(clk), .reset(reset), .q_in(q_in), .clear(clear),
        .ext_count(b_ext), .wrap(b_wrap), .step_err(b_serr),
        .err_cnt(b_err), .locked(b_lk), .fault(b_ft)
    );

    typedef struct {
        logic [3:0] q;
        logic       clr;
        int         ext;
        logic       wr;
        logic       se;
        int         err;
        logic       lk;
        logic       ft;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int idx,
                       input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s[%0d]: got %0d expected %0d",
                     nm, idx, act, exp);
        end
    endtask

    task automatic push(input int q, input int c, input int ext,
                        input int wr, input int se, input int err,
                        input int lk, input int ft);
        vec_t v;
        v.q   = 4'(q);
        v.clr = c[0];
        v.ext = ext;
        v.wr  = wr[0];
        v.se  = se[0];
        v.err = err;
        v.lk  = lk[0];
        v.ft  = ft[0];
        tbl.push_back(v);
    endtask

    task automatic step(input int q, input logic c);
        q_in  = 4'(q);
        clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string nm, input int idx);
        chk({nm, "_a_ext"}, idx, int'(a_ext), 0);
        chk({nm, "_a_wrap"}, idx, int'(a_wrap), 0);
        chk({nm, "_a_serr"}, idx, int'(a_serr), 0);
        chk({nm, "_a_err"}, idx, int'(a_err), 0);
        chk({nm, "_a_lk"}, idx, int'(a_lk), 0);
        chk({nm, "_a_ft"}, idx, int'(a_ft), 0);
        chk({nm, "_b_ext"}, idx, int'(b_ext), 0);
        chk({nm, "_b_lk"}, idx, int'(b_lk), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q_in  = 4'd0;
        clear = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Both instances see the same inputs; b differs only in ext width
    // and in hold policy, so hold-free tables check it too.
    task automatic run_tbl(input string nm);
        foreach (tbl[i]) begin
            step(int'(tbl[i].q), tbl[i].clr);
            chk({nm, "_ext"}, i, int'(a_ext), tbl[i].ext);
            chk({nm, "_wrap"}, i, int'(a_wrap), int'(tbl[i].wr));
            chk({nm, "_serr"}, i, int'(a_serr), int'(tbl[i].se));
            chk({nm, "_err"}, i, int'(a_err), tbl[i].err);
            chk({nm, "_lk"}, i, int'(a_lk), int'(tbl[i].lk));
            chk({nm, "_ft"}, i, int'(a_ft), int'(tbl[i].ft));
            chk({nm, "_bext"}, i, int'(b_ext), tbl[i].ext % 32);
            chk({nm, "_bwrap"}, i, int'(b_wrap), int'(tbl[i].wr));
            chk({nm, "_berr"}, i, int'(b_err), tbl[i].err);
            chk({nm, "_bft"}, i, int'(b_ft), int'(tbl[i].ft));
        end
        tbl.delete();
    endtask

    int hq[11]    = '{0, 0, 1, 2, 3, 4, 4, 4, 4, 5, 6};
    int ha_ext[11] = '{0, 0, 0, 1, 2, 3, 4, 4, 4, 4, 5};
    int hb_se[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
    int hb_err[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 3};
    int hb_ft[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    int hb_lk[11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};

    initial begin
        int q;

        // reset state
        repeat (2) @(negedge clk);
        check_zero("rst", 0);
        reset = 1'b0;

        // clean count: idle 0,0 then 1,2,...; lock on edge 2
        for (int n = 0; n < 40; n++)
            push((n <= 1) ? 0 : ((n - 1) & 15), 0,
                 (n >= 3) ? n - 2 : 0, (n == 18 || n == 34) ? 1 : 0,
                 0, 0, (n >= 2) ? 1 : 0, 0);
        run_tbl("clean");

        // async reset mid-cycle at ext_count 37
        #3;
        reset = 1'b1;
        #1;
        check_zero("async", 0);
        @(negedge clk);
        reset = 1'b0;
        push(0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 1, 0);
        run_tbl("relock");

        // single glitch 5 -> 9
        do_reset();
        push(0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0, 1, 0);
        push(2, 0, 1, 0, 0, 0, 1, 0);
        push(3, 0, 2, 0, 0, 0, 1, 0);
        push(4, 0, 3, 0, 0, 0, 1, 0);
        push(5, 0, 4, 0, 0, 0, 1, 0);
        push(9, 0, 5, 0, 0, 0, 1, 0);
        push(10, 0, 9, 0, 1, 1, 1, 0);
        push(11, 0, 10, 0, 0, 1, 1, 0);
        push(12, 0, 11, 0, 0, 1, 1, 0);
        run_tbl("glitch");

        // three consecutive bad steps -> fault, then clear
        do_reset();
        push(0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 0, 0);
        push(15, 0, 0, 0, 0, 0, 1, 0);
        push(14, 0, 15, 0, 1, 1, 1, 0);
        push(13, 0, 14, 0, 1, 2, 1, 0);
        push(12, 0, 13, 0, 1, 3, 0, 1);
        push(11, 0, 13, 0, 0, 3, 0, 1);
        push(10, 0, 13, 0, 0, 3, 0, 1);
        push(10, 1, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 1, 0);
        run_tbl("fault");

        // clear on the same edge as the third bad step
        do_reset();
        push(0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 0, 0);
        push(15, 0, 0, 0, 0, 0, 1, 0);
        push(14, 0, 15, 0, 1, 1, 1, 0);
        push(13, 0, 14, 0, 1, 2, 1, 0);
        push(12, 1, 0, 0, 0, 0, 0, 0);
        push(11, 0, 0, 0, 0, 0, 0, 0);
        push(10, 0, 0, 0, 0, 0, 0, 0);
        run_tbl("collide");

        // hold at 4: a tolerates it, b faults after three holds
        do_reset();
        for (int n = 0; n < 11; n++) begin
            step(hq[n], 1'b0);
            chk("hold_a_ext", n, int'(a_ext), ha_ext[n]);
            chk("hold_a_err", n, int'(a_err), 0);
            chk("hold_a_serr", n, int'(a_serr), 0);
            chk("hold_a_lk", n, int'(a_lk), (n >= 2) ? 1 : 0);
            chk("hold_b_ext", n, int'(b_ext), (n <= 6) ? ha_ext[n] : 4);
            chk("hold_b_serr", n, int'(b_serr), hb_se[n]);
            chk("hold_b_err", n, int'(b_err), hb_err[n]);
            chk("hold_b_lk", n, int'(b_lk), hb_lk[n]);
            chk("hold_b_ft", n, int'(b_ft), hb_ft[n]);
        end

        // alternating good/bad steps never fault but saturate err_cnt
        do_reset();
        step(0, 1'b0);
        step(0, 1'b0);
        q = 0;
        for (int i = 2; i < 620; i++) begin
            q = (q + (((i % 2) == 1) ? 5 : 1)) & 15;
            step(q, 1'b0);
        end
        chk("sat_a_err", 0, int'(a_err), 255);
        chk("sat_b_err", 0, int'(b_err), 255);
        chk("sat_a_lk", 0, int'(a_lk), 1);
        chk("sat_a_ft", 0, int'(a_ft), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
